ram_datos_arbiter: RTL and testbench

Two-port arbiter that shares the single 256x8 data RAM between the 8-bit Harvard CPU data port (port 0) and a second bus master (port 1: DMA/loader/debug). It owns the RAM address, write-data and RW lines, grants one requester at a time with round-robin fairness and a bounded burst, and returns registered read data and a one-cycle acknowledge per completed access. It sits between the masters and the data RAM in the top-level computer.

---
 rtl/ram_datos_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ram_datos_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_datos_arbiter.sv
// Arbiter sharing one 256x8 data RAM between the CPU data port (port 0) and a
// second bus master (port 1), with round-robin handover and a bounded burst.
module ram_datos_arbiter #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_rw,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam int            CW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic            acc0, acc1, burst_end;

  // Handshake: a port holds req (and, while ungranted, stable addr/we/wdata).
  // Each cycle with gnt=1 and req=1 is one access; its ack (and read data)
  // appears registered in the following cycle. req=0 while granted = no access.
  assign acc0      = (state_q == OWN0) && req0;
  assign acc1      = (state_q == OWN1) && req1;
  assign burst_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // Both requesting: the port that was not granted last goes first.
        if (req0 && (!req1 || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (req1) begin
          state_d = OWN1;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      OWN0: begin
        if (!req0) begin
          cnt_d   = '0;
          state_d = req1 ? OWN1 : IDLE;
          if (req1) last_d = 1'b1;
        end else if (burst_end) begin
          cnt_d = '0;
          if (req1) begin
            state_d = OWN1;
            last_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OWN1: begin
        if (!req1) begin
          cnt_d   = '0;
          state_d = req0 ? OWN0 : IDLE;
          if (req0) last_d = 1'b0;
        end else if (burst_end) begin
          cnt_d = '0;
          if (req0) begin
            state_d = OWN0;
            last_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // RAM lines are forced to zero outside access cycles so nothing strays.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_rw    = 1'b0;
    if (acc0) begin
      ram_addr  = addr0;
      ram_wdata = wdata0;
      ram_rw    = we0;
    end else if (acc1) begin
      ram_addr  = addr1;
      ram_wdata = wdata1;
      ram_rw    = we1;
    end
  end

  always_comb begin
    ack0_d   = acc0;
    ack1_d   = acc1;
    rdata0_d = (acc0 && !we0) ? ram_rdata : rdata0_q;
    rdata1_d = (acc1 && !we1) ? ram_rdata : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign gnt0        = (state_q == OWN0);
  assign gnt1        = (state_q == OWN1);
  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_datos_arbiter.sv
// Directed bench for ram_datos_arbiter: vector table plus hand sequences for
// reset-with-requests and asynchronous reset in the middle of a write burst.
module tb_ram_datos_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_rw;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  ram_datos_arbiter #(.DW(8), .AW(8), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .ack0       (ack0),
    .ack1       (ack1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rw     (ram_rw),
    .ram_rdata  (ram_rdata),
    .dbg_state_o(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Data RAM model: mem[i] starts as i, combinational read, write on edge.
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem_ready <= 1'b1;
    end else if (ram_rw) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  typedef struct {
    logic       r0, w0;
    logic [7:0] a0, d0;
    logic       r1, w1;
    logic [7:0] a1, d1;
    logic       g0, g1, k0, k1;
    logic [7:0] rd0, rd1;
    logic       rw;
    logic [7:0] ra;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
    input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
    input logic g0, input logic g1, input logic k0, input logic k1,
    input logic [7:0] rd0, input logic [7:0] rd1, input logic rw, input logic [7:0] ra);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.k0 = k0; v.k1 = k1;
    v.rd0 = rd0; v.rd1 = rd1; v.rw = rw; v.ra = ra;
    return v;
  endfunction

  // driver tasks
  task automatic apply(input vec_t v);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Row fields: port0 req/we/addr/wdata, port1 req/we/addr/wdata |
    // expected gnt0 gnt1 ack0 ack1 rdata0 rdata1 ram_rw ram_addr (this cycle).
    // Single write then read by port 0.
    vecs.push_back(mk(1'b1,1'b1,8'h10,8'hA5, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0, 8'h00,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b1,1'b1,8'h10,8'hA5, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0, 8'h00,8'h00,1'b1,8'h10));
    vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0, 8'h00,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0, 8'h00,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0, 8'h00,8'h00,1'b0,8'h10));
    vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0, 8'hA5,8'h00,1'b0,8'h00));
    // Both request from IDLE with port 0 granted last: port 1 first, 4 each.
    vecs.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b0,8'h81,8'h00, 1'b0,1'b0,1'b0,1'b0, 8'hA5,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b0,8'h81,8'h00, 1'b0,1'b1,1'b0,1'b0, 8'hA5,8'h00,1'b0,8'h81));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b0,8'h81,8'h00, 1'b0,1'b1,1'b0,1'b1, 8'hA5,8'h81,1'b0,8'h81));
    vecs.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b0,8'h81,8'h00, 1'b1,1'b0,1'b0,1'b1, 8'hA5,8'h81,1'b0,8'h40));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b0,8'h81,8'h00, 1'b1,1'b0,1'b1,1'b0, 8'h40,8'h81,1'b0,8'h40));
    vecs.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b0,8'h81,8'h00, 1'b0,1'b1,1'b1,1'b0, 8'h40,8'h81,1'b0,8'h81));
    // Port 1 releases after 2 accesses; port 0 takes over with no gap.
    vecs.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b0,8'h81,8'h00, 1'b0,1'b1,1'b0,1'b1, 8'h40,8'h81,1'b0,8'h81));
    vecs.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b1,1'b0,1'b1, 8'h40,8'h81,1'b0,8'h00));
    vecs.push_back(mk(1'b1,1'b1,8'h50,8'h3C, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0, 8'h40,8'h81,1'b1,8'h50));
    vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0, 8'h40,8'h81,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0, 8'h40,8'h81,1'b0,8'h00));
    // Lone port-1 burst of 10 reads with changing address; cnt wraps.
    vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h90,8'h00, 1'b0,1'b0,1'b0,1'b0, 8'h40,8'h81,1'b0,8'h00));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h90 + 8'(k),8'h00,
                        1'b0,1'b1,1'b0,(k > 0), 8'h40,(k == 0) ? 8'h81 : 8'h8F + 8'(k),
                        1'b0,8'h90 + 8'(k)));
    vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b1,1'b0,1'b1, 8'h40,8'h99,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0, 8'h40,8'h99,1'b0,8'h00));

    // Reset held with both ports requesting.
    rst = 1'b0;
    idle_inputs();
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h22; addr1 = 8'h33;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst gnt0", 8'(gnt0), 8'h00);
    chk("rst gnt1", 8'(gnt1), 8'h00);
    chk("rst ack0", 8'(ack0), 8'h00);
    chk("rst ack1", 8'(ack1), 8'h00);
    chk("rst rdata0", rdata0, 8'h00);
    chk("rst rdata1", rdata1, 8'h00);
    chk("rst ram_rw", 8'(ram_rw), 8'h00);
    chk("rst ram_addr", ram_addr, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("post-rst gnt0", 8'(gnt0), 8'h01);
    chk("post-rst gnt1", 8'(gnt1), 8'h00);
    chk("post-rst ram_addr", ram_addr, 8'h22);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("async rst gnt0", 8'(gnt0), 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1 apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("row%0d gnt0", i), 8'(gnt0), 8'(vecs[i].g0));
      chk($sformatf("row%0d gnt1", i), 8'(gnt1), 8'(vecs[i].g1));
      chk($sformatf("row%0d ack0", i), 8'(ack0), 8'(vecs[i].k0));
      chk($sformatf("row%0d ack1", i), 8'(ack1), 8'(vecs[i].k1));
      chk($sformatf("row%0d rdata0", i), rdata0, vecs[i].rd0);
      chk($sformatf("row%0d rdata1", i), rdata1, vecs[i].rd1);
      chk($sformatf("row%0d ram_rw", i), 8'(ram_rw), 8'(vecs[i].rw));
      chk($sformatf("row%0d ram_addr", i), ram_addr, vecs[i].ra);
    end

    // Write burst by port 0 cut by asynchronous reset between edges.
    @(posedge clk);
    #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h60; wdata0 = 8'h11;
    @(posedge clk);
    @(posedge clk);
    #1;
    addr0 = 8'h61; wdata0 = 8'h22;
    @(negedge clk);
    chk("burst gnt0", 8'(gnt0), 8'h01);
    chk("burst ram_rw", 8'(ram_rw), 8'h01);
    chk("burst ack0", 8'(ack0), 8'h01);
    #1 rst = 1'b0;
    #1;
    chk("midrst ram_rw", 8'(ram_rw), 8'h00);
    chk("midrst gnt0", 8'(gnt0), 8'h00);
    chk("midrst ack0", 8'(ack0), 8'h00);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after-rst ack0", 8'(ack0), 8'h00);
      chk("after-rst gnt0", 8'(gnt0), 8'h00);
      chk("after-rst ram_rw", 8'(ram_rw), 8'h00);
    end
    chk("after-rst rdata1", rdata1, 8'h00);
    chk("mem 60 written", mem[8'h60], 8'h11);
    chk("mem 61 untouched", mem[8'h61], 8'h61);
    chk("mem 10 written", mem[8'h10], 8'hA5);
    chk("mem 50 written", mem[8'h50], 8'h3C);
    chk("mem 70 untouched", mem[8'h70], 8'h70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
